// File: rtl/data_mem_port_pkg.sv
// Shared definitions for the data memory port: func3 load/store codes, FSM states,
// request payload and the byte-count helper.
package data_mem_port_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned CNT_WIDTH      = 3;

  localparam logic [1:0] IO_TAG_DEF = 2'b11;

  localparam logic [2:0] LSB_B  = 3'b000;
  localparam logic [2:0] LSB_H  = 3'b001;
  localparam logic [2:0] LSB_W  = 3'b010;
  localparam logic [2:0] LSB_BU = 3'b100;
  localparam logic [2:0] LSB_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } dport_state_e;

  // Latched request payload; the address is held separately so it can follow ADDR_WIDTH.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [2:0]            work_type;
  } dport_req_t;

  // Bytes moved by an access; the unused size code 2'b11 is treated as a word.
  function automatic logic [CNT_WIDTH-1:0] byte_count(input logic [2:0] func3);
    case (func3[1:0])
      2'b00:   byte_count = CNT_WIDTH'(1);
      2'b01:   byte_count = CNT_WIDTH'(2);
      default: byte_count = CNT_WIDTH'(4);
    endcase
  endfunction

endpackage

// File: rtl/data_mem_port_if.sv
// Request/response handshake with the load/store buffer plus the byte-wide RAM/IO bus.
interface data_mem_port_if
  import data_mem_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic                  need_data;
  logic                  is_write;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [2:0]            work_type;
  logic                  data_handle;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data_out;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport slave (
    input  need_data, is_write, data_addr, data_in, work_type, mem_din, io_buffer_full,
    output data_handle, data_ready, data_out, mem_dout, mem_a, mem_wr
  );

  modport master (
    output need_data, is_write, data_addr, data_in, work_type, mem_din, io_buffer_full,
    input  data_handle, data_ready, data_out, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/dport_load_extend.sv
// Sign/zero extension of an assembled load value according to its func3 code.
module dport_load_extend
  import data_mem_port_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] raw,
  input  logic [2:0]            work_type,
  output logic [DATA_WIDTH-1:0] ext
);

  always_comb begin
    ext = raw;
    case (work_type)
      LSB_B:   ext = {{24{raw[7]}}, raw[7:0]};
      LSB_BU:  ext = {24'b0, raw[7:0]};
      LSB_H:   ext = {{16{raw[15]}}, raw[15:0]};
      LSB_HU:  ext = {16'b0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// Serialises one load or store at a time onto the byte-wide RAM/IO bus and returns extended load data.
// Optional DPORT_IO_THROTTLE_EN: IO-tagged stores wait on io_buffer_full before each byte.
module data_mem_port
  import data_mem_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [1:0]  IO_TAG     = IO_TAG_DEF
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            rob_clear,
  data_mem_port_if.slave  bus
);

  dport_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]  k_q, k_d;
  logic [CNT_WIDTH-1:0]  n_bytes;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  dport_req_t            req_q, req_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d, asm_cap, ext_data;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_ready_q, data_ready_d;
  logic [1:0]            cap_idx;
  logic                  io_stall;
  logic                  accept;
  logic                  wr_en;

  assign n_bytes = byte_count(req_q.work_type);

  // Byte k-1 arrives on mem_din one cycle after its address was driven.
  assign cap_idx = 2'(k_q - CNT_WIDTH'(1));

  always_comb begin
    asm_cap = asm_q;
    asm_cap[{cap_idx, 3'b000} +: 8] = bus.mem_din;
  end

`ifdef DPORT_IO_THROTTLE_EN
  assign io_stall = (addr_q[17:16] == IO_TAG) && bus.io_buffer_full;
`else
  logic unused_io;
  assign io_stall  = 1'b0;
  assign unused_io = ^{bus.io_buffer_full, IO_TAG};
`endif

  dport_load_extend u_extend (
    .raw       (asm_cap),
    .work_type (req_q.work_type),
    .ext       (ext_data)
  );

  // Next-state, datapath and bus drive.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    addr_d       = addr_q;
    req_d        = req_q;
    asm_d        = asm_q;
    data_out_d   = data_out_q;
    data_ready_d = 1'b0;
    accept       = 1'b0;
    wr_en        = 1'b0;
    bus.mem_a    = '0;
    bus.mem_dout = '0;

    case (state_q)
      ST_IDLE: begin
        accept = bus.need_data && !rob_clear && rdy_in;
        if (accept) begin
          addr_d          = bus.data_addr;
          req_d.data      = bus.data_in;
          req_d.work_type = bus.work_type;
          k_d             = '0;
          asm_d           = '0;
          state_d         = bus.is_write ? ST_STORE : ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (k_q < n_bytes) begin
          bus.mem_a = addr_q + ADDR_WIDTH'(k_q);
        end
        if (rdy_in) begin
          if (rob_clear) begin
            state_d = ST_IDLE;
            k_d     = '0;
          end else begin
            if (k_q != '0) begin
              asm_d = asm_cap;
            end
            if (k_q == n_bytes) begin
              data_ready_d = 1'b1;
              data_out_d   = ext_data;
              state_d      = ST_IDLE;
              k_d          = '0;
            end else begin
              k_d = k_q + CNT_WIDTH'(1);
            end
          end
        end
      end

      ST_STORE: begin
        // A store always runs to completion; rob_clear is deliberately not consulted here.
        bus.mem_a    = addr_q + ADDR_WIDTH'(k_q);
        bus.mem_dout = req_q.data[{k_q[1:0], 3'b000} +: 8];
        wr_en        = rdy_in && !io_stall;
        if (wr_en) begin
          if (k_q == n_bytes - CNT_WIDTH'(1)) begin
            state_d = ST_IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + CNT_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
    endcase
  end

  assign bus.data_handle = accept;
  assign bus.mem_wr      = wr_en;
  assign bus.data_ready  = data_ready_q;
  assign bus.data_out    = data_out_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      addr_q       <= '0;
      req_q        <= '0;
      asm_q        <= '0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      asm_q        <= asm_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
    end
  end

endmodule
